// File: rtl/onehot_monitor.sv
// Pipelined one-hot classifier and lowest-set-bit encoder with optional debug error tracking.
// Define ONEHOT_MONITOR_ERR_CNT_EN to build the sticky violation flag and saturating counter.
module onehot_monitor #(
   parameter int unsigned Width     = 4,
   parameter int unsigned Latency   = 1,
   parameter bit          AllowZero = 1'b0,
   parameter int unsigned CntWidth  = 16,
   localparam int unsigned IdxW     = (Width > 1) ? $clog2(Width) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   input  logic [Width-1:0]    d_i,
   input  logic                clear_i,
   output logic                valid_o,
   output logic                is_onehot_o,
   output logic                is_zero_o,
   output logic                multi_hot_o,
   output logic [IdxW-1:0]     index_o,
   output logic                err_o,
   output logic                err_sticky_o,
   output logic [CntWidth-1:0] err_cnt_o
);

   localparam int unsigned Levels = (Width > 1) ? $clog2(Width) : 0;
   localparam int unsigned PadW   = 32'(1) << Levels;

   // Latency-1 registers spread evenly over tree positions 0..Levels-1; the output register is implicit.
   function automatic bit reg_after(input int unsigned lvl);
      bit hit;
      hit = 1'b0;
      for (int unsigned r = 1; r < Latency; r++) begin
         if (((r * Levels) / Latency) == lvl) hit = 1'b1;
      end
      return hit;
   endfunction

   logic [PadW-1:0] w_d_pad;
   assign w_d_pad = PadW'(d_i);

   for (genvar k = 0; k <= Levels; k++) begin : g_lvl
      localparam int unsigned N = PadW >> k;

      logic [N-1:0]      w_sum;
      logic [N-1:0]      w_carry;
      logic [N-1:0]      w_any;
      logic [N*IdxW-1:0] w_idx;
      logic              w_vld;

      logic [N-1:0]      w_s_q;
      logic [N-1:0]      w_c_q;
      logic [N-1:0]      w_a_q;
      logic [N*IdxW-1:0] w_i_q;
      logic              w_v_q;

      if (k == 0) begin : g_leaf
         assign w_sum   = w_d_pad;
         assign w_carry = '0;
         assign w_any   = w_d_pad;
         assign w_idx   = '0;
         assign w_vld   = valid_i;
      end else begin : g_node
         assign w_vld = g_lvl[k-1].w_v_q;
         for (genvar j = 0; j < N; j++) begin : g_pair
            logic            w_sa;
            logic            w_sb;
            logic            w_ca;
            logic            w_cb;
            logic            w_aa;
            logic            w_ab;
            logic [IdxW-1:0] w_ia;
            logic [IdxW-1:0] w_ib;

            assign w_sa = g_lvl[k-1].w_s_q[2*j];
            assign w_sb = g_lvl[k-1].w_s_q[2*j+1];
            assign w_ca = g_lvl[k-1].w_c_q[2*j];
            assign w_cb = g_lvl[k-1].w_c_q[2*j+1];
            assign w_aa = g_lvl[k-1].w_a_q[2*j];
            assign w_ab = g_lvl[k-1].w_a_q[2*j+1];
            assign w_ia = g_lvl[k-1].w_i_q[(2*j)*IdxW +: IdxW];
            assign w_ib = g_lvl[k-1].w_i_q[(2*j+1)*IdxW +: IdxW];

            // Half adder on the sums; any carry in the subtree means two or more bits set.
            assign w_sum[j]   = w_sa ^ w_sb;
            assign w_carry[j] = w_ca | w_cb | (w_sa & w_sb);
            assign w_any[j]   = w_aa | w_ab;
            // Lower half wins; the upper half's index gets this level's bit.
            assign w_idx[j*IdxW +: IdxW] = w_aa ? w_ia : (w_ib | IdxW'(32'(1) << (k-1)));
         end
      end

      if ((k < Levels) && reg_after(k)) begin : g_reg
         logic [N-1:0]      r_sum;
         logic [N-1:0]      r_carry;
         logic [N-1:0]      r_any;
         logic [N*IdxW-1:0] r_idx;
         logic              r_vld;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_vld <= 1'b0;
            end else begin
               r_vld <= w_vld;
            end
         end

         // Data slots update regardless of valid.
         always_ff @(posedge clk_i) begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
            r_any   <= w_any;
            r_idx   <= w_idx;
         end

         assign w_s_q = r_sum;
         assign w_c_q = r_carry;
         assign w_a_q = r_any;
         assign w_i_q = r_idx;
         assign w_v_q = r_vld;
      end else begin : g_pass
         assign w_s_q = w_sum;
         assign w_c_q = w_carry;
         assign w_a_q = w_any;
         assign w_i_q = w_idx;
         assign w_v_q = w_vld;
      end
   end

   logic            w_sum_f;
   logic            w_carry_f;
   logic            w_any_f;
   logic            w_vld_f;
   logic [IdxW-1:0] w_idx_f;
   logic            w_onehot;
   logic            w_zero;
   logic            w_multi;
   logic            w_err;
   logic [IdxW-1:0] w_index;

   assign w_sum_f   = g_lvl[Levels].w_s_q[0];
   assign w_carry_f = g_lvl[Levels].w_c_q[0];
   assign w_any_f   = g_lvl[Levels].w_a_q[0];
   assign w_idx_f   = g_lvl[Levels].w_i_q[IdxW-1:0];
   assign w_vld_f   = g_lvl[Levels].w_v_q;

   // Classification is forced to zero for invalid slots.
   assign w_onehot = w_vld_f & w_sum_f & ~w_carry_f;
   assign w_zero   = w_vld_f & ~w_any_f;
   assign w_multi  = w_vld_f & w_any_f & ~(w_sum_f & ~w_carry_f);
   assign w_err    = w_multi | (~AllowZero & w_zero);
   assign w_index  = (w_vld_f & w_any_f) ? w_idx_f : '0;

   logic            r_vld;
   logic            r_onehot;
   logic            r_zero;
   logic            r_multi;
   logic [IdxW-1:0] r_index;
   logic            r_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vld    <= 1'b0;
         r_onehot <= 1'b0;
         r_zero   <= 1'b0;
         r_multi  <= 1'b0;
         r_index  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_vld    <= w_vld_f;
         r_onehot <= w_onehot;
         r_zero   <= w_zero;
         r_multi  <= w_multi;
         r_index  <= w_index;
         r_err    <= w_err;
      end
   end

   assign valid_o     = r_vld;
   assign is_onehot_o = r_onehot;
   assign is_zero_o   = r_zero;
   assign multi_hot_o = r_multi;
   assign index_o     = r_index;
   assign err_o       = r_err;

`ifdef ONEHOT_MONITOR_ERR_CNT_EN
   logic                r_sticky;
   logic [CntWidth-1:0] r_cnt;

   // Clear takes effect before a coincident error is counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sticky <= 1'b0;
         r_cnt    <= '0;
      end else if (clear_i) begin
         r_sticky <= r_err;
         r_cnt    <= CntWidth'(r_err);
      end else if (r_err) begin
         r_sticky <= 1'b1;
         if (r_cnt != '1) r_cnt <= r_cnt + CntWidth'(1);
      end
   end

   assign err_sticky_o = r_sticky;
   assign err_cnt_o    = r_cnt;
`else
   logic w_unused_clear;
   assign w_unused_clear = clear_i;
   assign err_sticky_o   = 1'b0;
   assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_onehot_monitor.sv
// Randomized bench for onehot_monitor: four configurations checked against a popcount-based model.
module tb_onehot_monitor;

   localparam int NI    = 4;
   localparam int NEDGE = 560;
   localparam int MAXE  = 600;
   localparam int NDIR  = 40;

`ifdef ONEHOT_MONITOR_ERR_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [NI-1:0] in_v;
   logic [NI-1:0] in_c;
   logic [15:0]   in_d [NI];

   logic [NI-1:0] vo, oh, zo, mh, er, st;
   logic [3:0]  idx0;
   logic [2:0]  idx1;
   logic [0:0]  idx2;
   logic [3:0]  idx3;
   logic [1:0]  cnt0;
   logic [15:0] cnt1;
   logic [15:0] cnt2;
   logic [3:0]  cnt3;

   int n_total = 0;
   int n_bad   = 0;

   logic        h_v [NI][MAXE];
   logic        h_c [NI][MAXE];
   logic [15:0] h_d [NI][MAXE];
   logic        h_r [MAXE];

   logic        dir_v [NI][NDIR];
   logic        dir_c [NI][NDIR];
   logic [15:0] dir_d [NI][NDIR];

   int m_cnt  [NI];
   bit m_stk  [NI];
   bit m_perr [NI];

   always #5 clk = ~clk;

   onehot_monitor #(.Width(13), .Latency(4), .AllowZero(1'b0), .CntWidth(2)) u_m0 (
      .clk_i(clk), .rst_i(rst), .valid_i(in_v[0]), .d_i(in_d[0][12:0]), .clear_i(in_c[0]),
      .valid_o(vo[0]), .is_onehot_o(oh[0]), .is_zero_o(zo[0]), .multi_hot_o(mh[0]),
      .index_o(idx0), .err_o(er[0]), .err_sticky_o(st[0]), .err_cnt_o(cnt0));

   onehot_monitor #(.Width(8), .Latency(1), .AllowZero(1'b0), .CntWidth(16)) u_m1 (
      .clk_i(clk), .rst_i(rst), .valid_i(in_v[1]), .d_i(in_d[1][7:0]), .clear_i(in_c[1]),
      .valid_o(vo[1]), .is_onehot_o(oh[1]), .is_zero_o(zo[1]), .multi_hot_o(mh[1]),
      .index_o(idx1), .err_o(er[1]), .err_sticky_o(st[1]), .err_cnt_o(cnt1));

   onehot_monitor #(.Width(1), .Latency(1), .AllowZero(1'b1), .CntWidth(16)) u_m2 (
      .clk_i(clk), .rst_i(rst), .valid_i(in_v[2]), .d_i(in_d[2][0:0]), .clear_i(in_c[2]),
      .valid_o(vo[2]), .is_onehot_o(oh[2]), .is_zero_o(zo[2]), .multi_hot_o(mh[2]),
      .index_o(idx2), .err_o(er[2]), .err_sticky_o(st[2]), .err_cnt_o(cnt2));

   onehot_monitor #(.Width(16), .Latency(3), .AllowZero(1'b1), .CntWidth(4)) u_m3 (
      .clk_i(clk), .rst_i(rst), .valid_i(in_v[3]), .d_i(in_d[3]), .clear_i(in_c[3]),
      .valid_o(vo[3]), .is_onehot_o(oh[3]), .is_zero_o(zo[3]), .multi_hot_o(mh[3]),
      .index_o(idx3), .err_o(er[3]), .err_sticky_o(st[3]), .err_cnt_o(cnt3));

   function automatic int p_w(input int i);
      case (i)
         0: return 13;
         1: return 8;
         2: return 1;
         default: return 16;
      endcase
   endfunction

   function automatic int p_lat(input int i);
      case (i)
         0: return 4;
         3: return 3;
         default: return 1;
      endcase
   endfunction

   function automatic bit p_az(input int i);
      return (i >= 2);
   endfunction

   function automatic int p_cw(input int i);
      case (i)
         0: return 2;
         3: return 4;
         default: return 16;
      endcase
   endfunction

   function automatic logic [15:0] width_mask(input int w);
      return 16'((32'h1 << w) - 1);
   endfunction

   // Biased toward one-hot and zero vectors so every class shows up often.
   function automatic logic [15:0] gen_d(input int w);
      int r;
      r = $urandom_range(0, 99);
      if (r < 40) return 16'(32'h1 << $urandom_range(0, w - 1));
      else if (r < 55) return 16'h0;
      else return 16'($urandom) & width_mask(w);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int n);
      rst = (n <= 3) || (n == 30) || ((n >= NDIR) && ($urandom_range(0, 99) == 0));
      for (int i = 0; i < NI; i++) begin
         if (n < NDIR) begin
            in_v[i] = dir_v[i][n];
            in_d[i] = dir_d[i][n];
            in_c[i] = dir_c[i][n];
         end else begin
            in_v[i] = ($urandom_range(0, 3) != 0);
            in_d[i] = gen_d(p_w(i));
            in_c[i] = ($urandom_range(0, 99) < 4);
         end
         h_v[i][n] = in_v[i];
         h_d[i][n] = in_d[i];
         h_c[i][n] = in_c[i];
      end
      h_r[n] = rst;
   endtask

   // Output after edge t reflects the vector sampled at edge t-Latency+1 unless a reset hit since then.
   task automatic check_edge(input int t);
      for (int i = 0; i < NI; i++) begin
         int          es;
         bit          ev;
         logic [15:0] dd;
         int          pc;
         int          lo;
         bit          e_oh, e_z, e_m, e_err;
         int          e_idx;
         int          cmax;
         logic [31:0] g_idx, g_cnt;

         cmax = (1 << p_cw(i)) - 1;
         if (h_r[t]) begin
            m_stk[i] = 1'b0;
            m_cnt[i] = 0;
         end else if (h_c[i][t]) begin
            m_stk[i] = m_perr[i];
            m_cnt[i] = m_perr[i] ? 1 : 0;
         end else if (m_perr[i]) begin
            m_stk[i] = 1'b1;
            m_cnt[i] = (m_cnt[i] < cmax) ? m_cnt[i] + 1 : cmax;
         end

         es = t - p_lat(i) + 1;
         ev = (es >= 1);
         if (ev) begin
            ev = h_v[i][es];
            for (int e = es; e <= t; e++) if (h_r[e]) ev = 1'b0;
         end
         dd = ev ? (h_d[i][es] & width_mask(p_w(i))) : 16'h0;
         pc = $countones(dd);
         lo = 0;
         for (int b = 15; b >= 0; b--) if (dd[b]) lo = b;
         e_oh  = ev && (pc == 1);
         e_z   = ev && (pc == 0);
         e_m   = ev && (pc >= 2);
         e_idx = ev ? lo : 0;
         e_err = e_m || (e_z && !p_az(i));

         case (i)
            0: begin g_idx = 32'(idx0); g_cnt = 32'(cnt0); end
            1: begin g_idx = 32'(idx1); g_cnt = 32'(cnt1); end
            2: begin g_idx = 32'(idx2); g_cnt = 32'(cnt2); end
            default: begin g_idx = 32'(idx3); g_cnt = 32'(cnt3); end
         endcase

         check($sformatf("u%0d.valid@%0d", i, t),  32'(vo[i]), 32'(ev));
         check($sformatf("u%0d.onehot@%0d", i, t), 32'(oh[i]), 32'(e_oh));
         check($sformatf("u%0d.zero@%0d", i, t),   32'(zo[i]), 32'(e_z));
         check($sformatf("u%0d.multi@%0d", i, t),  32'(mh[i]), 32'(e_m));
         check($sformatf("u%0d.index@%0d", i, t),  g_idx,      32'(e_idx));
         check($sformatf("u%0d.err@%0d", i, t),    32'(er[i]), 32'(e_err));
         check($sformatf("u%0d.sticky@%0d", i, t), 32'(st[i]), CntEn ? 32'(m_stk[i]) : 32'h0);
         check($sformatf("u%0d.cnt@%0d", i, t),    g_cnt,      CntEn ? 32'(m_cnt[i]) : 32'h0);

         m_perr[i] = e_err;
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         m_cnt[i]  = 0;
         m_stk[i]  = 1'b0;
         m_perr[i] = 1'b0;
         for (int n = 0; n < NDIR; n++) begin
            dir_v[i][n] = 1'b0;
            dir_c[i][n] = 1'b0;
            dir_d[i][n] = gen_d(p_w(i));
         end
      end
      // Width 13: every one-hot position, all-ones, a run of violations, then a clear against a live error.
      for (int n = 4; n <= 16; n++) begin
         dir_v[0][n] = 1'b1;
         dir_d[0][n] = 16'(32'h1 << (n - 4));
      end
      dir_v[0][17] = 1'b1; dir_d[0][17] = 16'h1FFF;
      for (int n = 18; n <= 22; n++) begin
         dir_v[0][n] = 1'b1;
         dir_d[0][n] = 16'h0003;
      end
      dir_v[0][23] = 1'b1; dir_d[0][23] = 16'h0000;
      dir_c[0][26] = 1'b1;
      // Width 8: one-hot, zero, multi-hot with low bit set.
      dir_v[1][4] = 1'b1; dir_d[1][4] = 16'h0010;
      dir_v[1][5] = 1'b1; dir_d[1][5] = 16'h0000;
      dir_v[1][6] = 1'b1; dir_d[1][6] = 16'h0081;
      // Width 1 with zero allowed.
      dir_v[2][4] = 1'b1; dir_d[2][4] = 16'h0001;
      dir_v[2][5] = 1'b1; dir_d[2][5] = 16'h0000;
      // Latency 3: vectors in flight when reset pulses at edge 30.
      dir_v[3][28] = 1'b1; dir_d[3][28] = 16'h0001;
      dir_v[3][29] = 1'b1; dir_d[3][29] = 16'h0100;
      dir_v[3][30] = 1'b1; dir_d[3][30] = 16'hFFFF;

      drive(1);
      for (int t = 1; t <= NEDGE; t++) begin
         @(posedge clk);
         #1;
         check_edge(t);
         drive(t + 1);
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
